// File: rtl/pmem_responder_pkg.sv
// pmem_types: shared widths, burst geometry and FSM state encoding for the
// pmem responder slice.
package pmem_types;

  localparam int unsigned BURST_LEN     = 4;
  localparam int unsigned LINE_BITS     = 256;
  localparam int unsigned BEAT_BITS     = 64;
  localparam int unsigned BEAT_IDX_BITS = 2;
  localparam int unsigned LAT_CNT_BITS  = 8;
  localparam int unsigned ADDR_BITS     = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } pmem_state_t;

  // One-hot beat enable for the line array write port.
  function automatic logic [BURST_LEN-1:0] beat_onehot(input logic [BEAT_IDX_BITS-1:0] beat);
    beat_onehot = BURST_LEN'(1) << beat;
  endfunction

endpackage

// File: rtl/pmem_responder_if.sv
// pmem_responder_if: line-burst memory port.
//   pmem_address/read/write/wdata : initiator -> responder
//   pmem_rdata/resp/error         : responder -> initiator
interface pmem_responder_if;
  import pmem_types::*;

  logic [ADDR_BITS-1:0] pmem_address;
  logic                 pmem_read;
  logic                 pmem_write;
  logic [BEAT_BITS-1:0] pmem_wdata;
  logic [BEAT_BITS-1:0] pmem_rdata;
  logic                 pmem_resp;
  logic                 pmem_error;

  modport slave (
    input  pmem_address, pmem_read, pmem_write, pmem_wdata,
    output pmem_rdata, pmem_resp, pmem_error
  );

  modport master (
    output pmem_address, pmem_read, pmem_write, pmem_wdata,
    input  pmem_rdata, pmem_resp, pmem_error
  );
endinterface

// File: rtl/pmem_line_array.sv
// pmem_line_array: 2^LINE_IDX_BITS x 256-bit line storage, no reset.
//   clk          : write clock
//   rd_idx       : combinational read line index
//   rd_line      : full line at rd_idx
//   wr_idx       : write line index
//   wr_beat_en   : per-beat write enable (one bit per 64-bit beat)
//   wr_beat_data : beat data written into every enabled beat
module pmem_line_array
  import pmem_types::*;
#(
  parameter int unsigned LINE_IDX_BITS = 8
) (
  input  logic                     clk,
  input  logic [LINE_IDX_BITS-1:0] rd_idx,
  output logic [LINE_BITS-1:0]     rd_line,
  input  logic [LINE_IDX_BITS-1:0] wr_idx,
  input  logic [BURST_LEN-1:0]     wr_beat_en,
  input  logic [BEAT_BITS-1:0]     wr_beat_data
);

  localparam int unsigned DEPTH = 1 << LINE_IDX_BITS;

  logic [LINE_BITS-1:0] mem_q [DEPTH];

  assign rd_line = mem_q[rd_idx];

  // Beat-granular write; untouched beats keep their contents.
  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(BURST_LEN); b++) begin
      if (wr_beat_en[b]) begin
        mem_q[wr_idx][b*BEAT_BITS +: BEAT_BITS] <= wr_beat_data;
      end
    end
  end

endmodule

// File: rtl/pmem_responder.sv
// pmem_responder: fixed-latency line-burst memory responder.
//   clk  : single clock, rising edge
//   rst  : asynchronous active-low reset
//   pmem : slave side of the line-burst port (4 x 64-bit beats per line)
// A request accepted in IDLE waits LATENCY cycles, then streams 4 beats.
// Protocol violations set a sticky error flag cleared only by reset.
module pmem_responder
  import pmem_types::*;
#(
  parameter int unsigned LATENCY       = 10,
  parameter int unsigned LINE_IDX_BITS = 8
) (
  input  logic            clk,
  input  logic            rst,
  pmem_responder_if.slave pmem
);

  pmem_state_t               state_q, state_d;
  logic [LAT_CNT_BITS-1:0]   wait_cnt_q, wait_cnt_d;
  logic [BEAT_IDX_BITS-1:0]  beat_q, beat_d;
  logic [LINE_IDX_BITS-1:0]  idx_q, idx_d;
  logic                      dir_rd_q, dir_rd_d;
  logic                      error_q, error_d;

  logic                      req_held;
  logic [LINE_BITS-1:0]      line;
  logic [BURST_LEN-1:0]      wr_beat_en;

  // Next-state, counters, latched request and error.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    beat_d     = beat_q;
    idx_d      = idx_q;
    dir_rd_d   = dir_rd_q;
    error_d    = error_q;
    // The initiator must keep the original direction's strobe high.
    req_held   = dir_rd_q ? pmem.pmem_read : pmem.pmem_write;

    unique case (state_q)
      IDLE: begin
        if (pmem.pmem_read || pmem.pmem_write) begin
          idx_d      = pmem.pmem_address[LINE_IDX_BITS+4:5];
          dir_rd_d   = pmem.pmem_read;   // read wins a simultaneous request
          wait_cnt_d = LAT_CNT_BITS'(LATENCY - 1);
          state_d    = WAIT;
          if (pmem.pmem_read && pmem.pmem_write) begin
            error_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!req_held) begin
          error_d = 1'b1;
        end
        if (wait_cnt_q == '0) begin
          beat_d  = '0;
          state_d = BURST;
        end else begin
          wait_cnt_d = wait_cnt_q - LAT_CNT_BITS'(1);
        end
      end
      BURST: begin
        if (!req_held) begin
          error_d = 1'b1;
        end
        beat_d = beat_q + BEAT_IDX_BITS'(1);
        if (beat_q == BEAT_IDX_BITS'(BURST_LEN - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      beat_q     <= '0;
      idx_q      <= '0;
      dir_rd_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      beat_q     <= beat_d;
      idx_q      <= idx_d;
      dir_rd_q   <= dir_rd_d;
      error_q    <= error_d;
    end
  end

  // Write beats land at the edge that ends each beat.
  assign wr_beat_en = (state_q == BURST && !dir_rd_q) ? beat_onehot(beat_q) : '0;

  pmem_line_array #(
    .LINE_IDX_BITS(LINE_IDX_BITS)
  ) u_line_array (
    .clk          (clk),
    .rd_idx       (idx_q),
    .rd_line      (line),
    .wr_idx       (idx_q),
    .wr_beat_en   (wr_beat_en),
    .wr_beat_data (pmem.pmem_wdata)
  );

  // Strobe and read data decode straight from state so reset drops them at once.
  assign pmem.pmem_resp  = (state_q == BURST);
  assign pmem.pmem_rdata = (state_q == BURST) ? line[32'(beat_q)*BEAT_BITS +: BEAT_BITS] : '0;
  assign pmem.pmem_error = error_q;

endmodule

// File: doc/pmem_responder.md
PMEM_RESPONDER -- requirements
Module: pmem_responder

Interface
REQ-001 Parameter LATENCY, default 10, wait cycles between request acceptance and first data beat; legal range 1..255.
REQ-002 Parameter LINE_IDX_BITS, default 8, log2 of the number of 256-bit lines stored (256 lines = 8 KiB).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 pmem_address  input  32  byte address of the requested line; bits [4:0] ignored.
REQ-006 pmem_read  input  1  line read request, held high by the initiator until the last beat.
REQ-007 pmem_write  input  1  line write request, held high by the initiator until the last beat.
REQ-008 pmem_wdata  input  64  write beat data, valid on every cycle where pmem_resp is high during a write.
REQ-009 pmem_rdata  output  64  read beat data, valid on every cycle where pmem_resp is high during a read.
REQ-010 pmem_resp  output  1  beat strobe, high for exactly 4 consecutive cycles per transaction.
REQ-011 pmem_error  output  1  sticky protocol-violation flag.

Function
REQ-012 States: IDLE, WAIT, BURST, DONE; encoding taken from the shared package.
REQ-013 IDLE: on an edge with pmem_read or pmem_write high, latch line index = pmem_address[LINE_IDX_BITS+4:5] and the direction, load the wait counter with LATENCY-1, and go to WAIT.
REQ-014 Both pmem_read and pmem_write high in IDLE: read wins, write ignored, pmem_error set.
REQ-015 WAIT: decrement the counter each cycle; at zero, go to BURST with beat counter = 0.
REQ-016 Timing: a request first sampled at edge k gives pmem_resp high during cycles k+LATENCY+1 .. k+LATENCY+4.
REQ-017 BURST: pmem_resp = 1 and the beat counter (2 bits) advances each cycle; after beat 3, go to DONE.
REQ-018 Read beat i: pmem_rdata = line[64*i+63 : 64*i], combinational from the latched index and beat counter.
REQ-019 Write beat i: pmem_wdata is written into line[64*i+63 : 64*i] at the edge ending that beat; other beats of the line are unchanged.
REQ-020 Outside BURST: pmem_resp = 0 and pmem_rdata = 0.
REQ-021 DONE: lasts one cycle with pmem_resp = 0, then returns to IDLE; a request still high in DONE is not accepted until IDLE.
REQ-022 The minimum gap between the last beat of one transaction and acceptance of the next is 1 cycle; back-to-back lines therefore use a 2-edge turnaround.
REQ-023 A request deasserted or changed direction during WAIT or BURST sets pmem_error; the burst still completes all 4 beats with the original direction and index.
REQ-024 An address beyond the storage depth wraps modulo 2^LINE_IDX_BITS lines; this sets no error.
REQ-025 pmem_address is ignored outside IDLE.
REQ-026 pmem_error is cleared only by reset.

Reset
REQ-027 rst low asynchronously forces state = IDLE, counters = 0, pmem_resp = 0, pmem_rdata = 0, pmem_error = 0.
REQ-028 Reset mid-burst aborts the transaction with no further beats; line contents already written are retained, a partially written line keeps its written beats, and the array is never cleared.
REQ-029 After rst rises, the first request is accepted on the first rising edge at which it is sampled high.

Structure
REQ-030 The shared package pmem_types holds: BURST_LEN = 4, LINE_BITS = 256, BEAT_BITS = 64, and the enum pmem_state_t {IDLE, WAIT, BURST, DONE}.
REQ-031 Sub-module pmem_line_array: 2^LINE_IDX_BITS x 256-bit storage with one read port (combinational read) and one write port with a 4-bit beat-enable; it has no reset.
REQ-032 pmem_responder contains only the FSM, counters, latched index/direction and error logic; it plugs into the existing top-level pmem port without adaptation.

Verification
REQ-033 Write then read, LATENCY = 10: write address 0x00000040 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44; pmem_resp is high at k+11..k+14. A following read of 0x00000040 returns the same 4 beats in order.
REQ-034 Simultaneous request: pmem_read = pmem_write = 1 at address 0x40 -> 4 read beats are returned, the line is unchanged, and pmem_error = 1 stays set.
REQ-035 Wrap-around, LINE_IDX_BITS = 8: write 0x00002040 with beats 0xA5..A5 -> a read of 0x00000040 returns 0xA5..A5 on all 4 beats.
REQ-036 Mid-burst reset: assert rst low during beat 2 of a write -> pmem_resp falls immediately. A subsequent read of that line returns the new beats 0-1 and the old beats 2-3.
REQ-037 Early deassert: drop pmem_read during WAIT -> 4 beats are still issued, then DONE, and pmem_error = 1.
REQ-038 Latency edge case, LATENCY = 1: request at edge k -> pmem_resp is high at k+2..k+5, and the next request held high is accepted at k+7.
